// File: rtl/pipe_stage_reg.sv
// Generic elastic pipeline stage register with valid/ready handshake,
// flush-to-bubble and an optional one-entry skid buffer.
module pipe_stage_reg #(
  parameter int              DW      = 128,
  parameter int              SKID    = 0,
  parameter logic [DW-1:0]   NOP_VAL = '0
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          flush,
  output logic [1:0]    occ
);

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FULL    = 2'd1;
  localparam logic [1:0] SKIDDED = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [DW-1:0] main_q;
  logic [DW-1:0] main_n;
  logic [DW-1:0] skid_q;
  logic [DW-1:0] skid_n;
  logic          rdy_q;
  logic          xin;
  logic          xout;

  assign out_valid = (state != EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VAL;
  assign occ       = state;

  // With SKID=1 the ready flag is a flop, so out_ready never reaches in_ready.
  assign in_ready = (SKID != 0) ? rdy_q : (!out_valid || out_ready);

  assign xin  = in_valid && in_ready;
  assign xout = out_valid && out_ready;

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    case (state)
      EMPTY: begin
        if (xin) begin
          state_n = FULL;
          main_n  = in_data;
        end
      end
      FULL: begin
        // Only reachable with a skid register: SKID=0 blocks in without out.
        if (xin && !xout) begin
          state_n = SKIDDED;
          skid_n  = in_data;
        end else if (xin) begin
          main_n = in_data;
        end else if (xout) begin
          state_n = EMPTY;
        end
      end
      SKIDDED: begin
        if (xout) begin
          state_n = FULL;
          main_n  = skid_q;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      state  <= EMPTY;
      main_q <= NOP_VAL;
      skid_q <= NOP_VAL;
      rdy_q  <= 1'b1;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
      rdy_q  <= (state_n != SKIDDED);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one instance per SKID mode,
// driven in lockstep with hand-computed expectations.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam logic [DW-1:0] NOP = 16'hDEAD;

  logic CLK = 1'b0;
  logic nRST;
  logic flush;

  logic          iv0, ir0, ov0, or0;
  logic [DW-1:0] id0, od0;
  logic [1:0]    oc0;
  logic          iv1, ir1, ov1, or1;
  logic [DW-1:0] id1, od1;
  logic [1:0]    oc1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.DW(DW), .SKID(0), .NOP_VAL(NOP)) u0 (
    .CLK(CLK), .nRST(nRST),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .flush(flush), .occ(oc0)
  );

  pipe_stage_reg #(.DW(DW), .SKID(1), .NOP_VAL(NOP)) u1 (
    .CLK(CLK), .nRST(nRST),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .flush(flush), .occ(oc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks run 1 unit later.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0;
    iv0 = 1'b1; id0 = 16'hAAAA; or0 = 1'b0;
    iv1 = 1'b1; id1 = 16'hAAAA; or1 = 1'b0;
    #1;
    cyc(); cyc();
    iv0 = 1'b0; iv1 = 1'b0; nRST = 1'b1;
    settle();
    chk("rst_ov0", 32'(ov0), 32'd0);
    chk("rst_od0", 32'(od0), 32'(NOP));
    chk("rst_oc0", 32'(oc0), 32'd0);
    chk("rst_ir0", 32'(ir0), 32'd1);
    chk("rst_ov1", 32'(ov1), 32'd0);
    chk("rst_od1", 32'(od1), 32'(NOP));
    chk("rst_oc1", 32'(oc1), 32'd0);
    chk("rst_ir1", 32'(ir1), 32'd1);

    // Streaming 1..8, out_ready held high
    or0 = 1'b1; or1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      iv0 = 1'b1; id0 = 16'(k);
      iv1 = 1'b1; id1 = 16'(k);
      cyc();
      chk("str_ov0", 32'(ov0), 32'd1);
      chk("str_od0", 32'(od0), 32'(k));
      chk("str_ov1", 32'(ov1), 32'd1);
      chk("str_od1", 32'(od1), 32'(k));
      chk("str_ir1", 32'(ir1), 32'd1);
      chk("str_oc1", 32'(oc1), 32'd1);
    end
    iv0 = 1'b0; iv1 = 1'b0;
    cyc();
    chk("str_end_ov0", 32'(ov0), 32'd0);
    chk("str_end_ov1", 32'(ov1), 32'd0);
    chk("str_end_oc1", 32'(oc1), 32'd0);

    // SKID=1 stall: two entries, then drain
    or1 = 1'b0;
    iv1 = 1'b1; id1 = 16'h0011;
    cyc();
    chk("stl1_ir_a", 32'(ir1), 32'd1);
    id1 = 16'h0022;
    cyc();
    iv1 = 1'b0;
    chk("stl1_occ", 32'(oc1), 32'd2);
    chk("stl1_ir_b", 32'(ir1), 32'd0);
    chk("stl1_od_a", 32'(od1), 32'h0011);
    or1 = 1'b1;
    settle();
    chk("stl1_ir_comb", 32'(ir1), 32'd0);
    cyc();
    chk("stl1_od_b", 32'(od1), 32'h0022);
    chk("stl1_occ_b", 32'(oc1), 32'd1);
    chk("stl1_ir_c", 32'(ir1), 32'd1);
    cyc();
    chk("stl1_ov_end", 32'(ov1), 32'd0);

    // SKID=0 stall: 0x33 held while downstream blocks
    or0 = 1'b0;
    iv0 = 1'b1; id0 = 16'h0033;
    cyc();
    id0 = 16'h0099;
    settle();
    chk("stl0_ir", 32'(ir0), 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stl0_od", 32'(od0), 32'h0033);
      chk("stl0_ov", 32'(ov0), 32'd1);
    end
    iv0 = 1'b0; or0 = 1'b1;
    settle();
    chk("stl0_ir_open", 32'(ir0), 32'd1);
    cyc();
    chk("stl0_ov_end", 32'(ov0), 32'd0);

    // Flush while SKIDDED; SKID=0 instance drops a same-cycle input
    or1 = 1'b0;
    iv1 = 1'b1; id1 = 16'h000A;
    cyc();
    id1 = 16'h000B;
    cyc();
    chk("fl_pre_occ", 32'(oc1), 32'd2);
    flush = 1'b1;
    iv1 = 1'b1; id1 = 16'h0044;
    iv0 = 1'b1; id0 = 16'h0045;
    settle();
    chk("fl_ir0", 32'(ir0), 32'd1);
    cyc();
    flush = 1'b0; iv0 = 1'b0; iv1 = 1'b0;
    or0 = 1'b1; or1 = 1'b1;
    chk("fl_occ1", 32'(oc1), 32'd0);
    chk("fl_ov1", 32'(ov1), 32'd0);
    chk("fl_od1", 32'(od1), 32'(NOP));
    chk("fl_ir1", 32'(ir1), 32'd1);
    chk("fl_occ0", 32'(oc0), 32'd0);
    chk("fl_ov0", 32'(ov0), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("fl_post_ov1", 32'(ov1), 32'd0);
      chk("fl_post_ov0", 32'(ov0), 32'd0);
    end

    // Simultaneous in/out on SKID=1 FULL
    or1 = 1'b0;
    iv1 = 1'b1; id1 = 16'h0055;
    cyc();
    id1 = 16'h0066; or1 = 1'b1;
    settle();
    chk("sim_od_a", 32'(od1), 32'h0055);
    cyc();
    iv1 = 1'b0; or1 = 1'b0;
    chk("sim_od_b", 32'(od1), 32'h0066);
    chk("sim_occ", 32'(oc1), 32'd1);
    chk("sim_ir", 32'(ir1), 32'd1);

    // Reset mid-operation discards everything
    iv1 = 1'b1; id1 = 16'h0077;
    cyc();
    iv1 = 1'b0;
    chk("mr_pre_occ", 32'(oc1), 32'd2);
    nRST = 1'b0;
    cyc();
    nRST = 1'b1;
    chk("mr_occ", 32'(oc1), 32'd0);
    chk("mr_ov", 32'(ov1), 32'd0);
    chk("mr_od", 32'(od1), 32'(NOP));
    chk("mr_ir", 32'(ir1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
